regfile_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single register-file write port among NUM_REQ requesters, for example the ALU, the load unit and the immediate-move path.
- The winning request is registered into a one-entry output stage.
- That stage drives the write-enable, the demux select and the data into the 1-to-8 register demux and the register bank.
- Sits between the execute/writeback sources and the register file.

---
 rtl/regfile_pkg.sv | 26 ++
 rtl/regfile_wr_arbiter_rr_pick.sv | 32 +++
 rtl/regfile_wr_arbiter.sv | 111 +++++++++++
 tb/tb_regfile_wr_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Register-file write-path package shared by the write arbiter.
// Holds the register bank geometry, the request typedefs and a helper
// that flags more than one active request bit.
package regfile_pkg;

  localparam int unsigned REG_ADDR_BITS = 3;
  localparam int unsigned REG_DATA_BITS = 8;
  localparam int unsigned NUM_REGS      = 8;

  // Widest requester vector the arbiter supports.
  localparam int unsigned MAX_REQ       = 8;

  typedef logic [REG_ADDR_BITS-1:0] reg_addr_t;
  typedef logic [REG_DATA_BITS-1:0] reg_data_t;

  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wr_req_t;

  // True when two or more bits of v are set.
  function automatic logic multi_hot(input logic [MAX_REQ-1:0] v);
    return (v & (v - 1'b1)) != '0;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin one-hot picker.
// Ports:
//   valid [NUM_REQ]  request vector
//   ptr   [PTR_BITS] index scanned first
//   gnt   [NUM_REQ]  one-hot grant of the first valid index at or after ptr,
//                    wrapping modulo NUM_REQ; all zeros when nothing is valid
module rr_pick #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned PTR_BITS = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  valid,
  input  logic [PTR_BITS-1:0] ptr,
  output logic [NUM_REQ-1:0]  gnt
);

  logic                found;
  logic [PTR_BITS-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PTR_BITS'((32'(ptr) + k) % NUM_REQ);
      if (!found && valid[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin arbiter sharing the single register-file
// write port among NUM_REQ requesters, with a one-entry registered output
// stage feeding the register demux and bank.
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   req_valid/addr/data  packed per-requester write requests
//   req_ready         combinational one-hot grant (zero while wr_stall)
//   wr_stall          register file cannot accept this cycle
//   wr_en/wr_sel/wr_data/wr_src  registered write to the register file
// Optional (macro REGFILE_WR_ARB_STATS_EN):
//   conflict_cnt      saturating count of unstalled multi-request cycles
//   stall_cnt         saturating count of stalled cycles holding a write
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_BITS = REG_DATA_BITS,
  parameter int unsigned ADDR_BITS = REG_ADDR_BITS,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned SRC_BITS  = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_BITS-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_BITS-1:0]  req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wr_stall,
  output logic                          wr_en,
  output logic [ADDR_BITS-1:0]          wr_sel,
  output logic [DATA_BITS-1:0]          wr_data,
  output logic [SRC_BITS-1:0]           wr_src
`ifdef REGFILE_WR_ARB_STATS_EN
  ,
  output logic [15:0]                   conflict_cnt,
  output logic [15:0]                   stall_cnt
`endif
);

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [SRC_BITS-1:0]  rr_ptr;
  logic [SRC_BITS-1:0]  gidx;
  logic [SRC_BITS-1:0]  ptr_next;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [DATA_BITS-1:0] sel_data;
  logic                 any_gnt;

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .PTR_BITS (SRC_BITS)
  ) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .gnt   (pick_gnt)
  );

  always_comb begin
    req_ready = wr_stall ? '0 : pick_gnt;
    any_gnt   = |req_ready;
  end

  // Encode the one-hot grant and mux out the winner's address and data.
  always_comb begin
    gidx     = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        gidx     = SRC_BITS'(i);
        sel_addr = req_addr[i*ADDR_BITS +: ADDR_BITS];
        sel_data = req_data[i*DATA_BITS +: DATA_BITS];
      end
    end
    ptr_next = (gidx == SRC_BITS'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
  end

  // Stall freezes the whole stage, so a pending write is re-presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_sel  <= '0;
      wr_data <= '0;
      wr_src  <= '0;
      rr_ptr  <= '0;
    end else if (!wr_stall) begin
      if (any_gnt) begin
        wr_en   <= 1'b1;
        wr_sel  <= sel_addr;
        wr_data <= sel_data;
        wr_src  <= gidx;
        rr_ptr  <= ptr_next;
      end else begin
        wr_en   <= 1'b0;
      end
    end
  end

`ifdef REGFILE_WR_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (!wr_stall && multi_hot(MAX_REQ'(req_valid)) && conflict_cnt != '1)
        conflict_cnt <= conflict_cnt + 1'b1;
      if (wr_stall && wr_en && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with NUM_REQ=4, 8-bit data, 3-bit
// register index. Also watches the requester hold rule.
module tb_regfile_wr_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AB = 3;
  localparam int unsigned DB = 8;
  localparam int unsigned SB = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*AB-1:0] req_addr;
  logic [NR*DB-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             wr_stall;
  logic             wr_en;
  logic [AB-1:0]    wr_sel;
  logic [DB-1:0]    wr_data;
  logic [SB-1:0]    wr_src;
`ifdef REGFILE_WR_ARB_STATS_EN
  logic [15:0]      conflict_cnt;
  logic [15:0]      stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  regfile_wr_arbiter #(
    .DATA_BITS (DB),
    .ADDR_BITS (AB),
    .NUM_REQ   (NR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_stall  (wr_stall),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .wr_src    (wr_src)
`ifdef REGFILE_WR_ARB_STATS_EN
    ,
    .conflict_cnt (conflict_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int unsigned i, input logic [AB-1:0] a, input logic [DB-1:0] d);
    req_addr[i*AB +: AB] = a;
    req_data[i*DB +: DB] = d;
  endtask

  task automatic chk_out(input string tag, input logic en, input logic [AB-1:0] sel,
                         input logic [DB-1:0] data, input logic [SB-1:0] src);
    chk({tag, ".wr_en"},   32'(wr_en),   32'(en));
    chk({tag, ".wr_sel"},  32'(wr_sel),  32'(sel));
    chk({tag, ".wr_data"}, 32'(wr_data), 32'(data));
    chk({tag, ".wr_src"},  32'(wr_src),  32'(src));
  endtask

  // A requester that was valid but not granted must still be valid next edge.
  logic [NR-1:0] pend;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= '0;
    end else begin
      tests++;
      assert ((pend & ~req_valid) == '0) else begin
        fails++;
        $error("FAIL proto_hold: dropped %b expected 0000", pend & ~req_valid);
      end
      pend <= req_valid & ~req_ready;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    wr_stall  = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    tick();
    tick();
    reset = 1'b0;
    settle();
    chk_out("reset", 1'b0, 3'd0, 8'h00, 2'd0);
    chk("reset.ready", 32'(req_ready), 32'h0);
`ifdef REGFILE_WR_ARB_STATS_EN
    chk("reset.conflict_cnt", 32'(conflict_cnt), 32'd0);
    chk("reset.stall_cnt",    32'(stall_cnt),    32'd0);
`endif
    tick();
    tick();
    chk("idle.wr_en", 32'(wr_en), 32'd0);
    chk("idle.ready", 32'(req_ready), 32'h0);

    // Asynchronous reset in the middle of a cycle drops the pending write.
    set_req(0, 3'd1, 8'h55);
    req_valid = 4'b0001;
    settle();
    chk("async.ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    chk_out("async.load", 1'b1, 3'd1, 8'h55, 2'd0);
    #2;
    reset = 1'b1;
    #1;
    chk_out("async.reset", 1'b0, 3'd0, 8'h00, 2'd0);
    chk("async.ready0", 32'(req_ready), 32'h0);
    #1;
    reset = 1'b0;
    tick();

    // Single requester 2.
    set_req(2, 3'd5, 8'hA7);
    req_valid = 4'b0100;
    settle();
    chk("single.ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    chk_out("single.load", 1'b1, 3'd5, 8'hA7, 2'd2);
    req_valid = 4'b1111;
    settle();
    chk("single.ptr3", 32'(req_ready), 32'b1000);
    req_valid = '0;
    settle();
    tick();
    chk_out("single.idle_hold", 1'b0, 3'd5, 8'hA7, 2'd2);

    // Full contention from reset: grant order 0,1,2,3,0,1,2,3.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    for (int unsigned i = 0; i < NR; i++)
      set_req(i, AB'(i), DB'(8'h10 + i));
    req_valid = 4'b1111;
    settle();
    for (int unsigned k = 0; k < 8; k++) begin
      chk($sformatf("full.ready%0d", k), 32'(req_ready), 32'(1) << (k % NR));
      tick();
      chk_out($sformatf("full.out%0d", k), 1'b1, AB'(k % NR), DB'(8'h10 + (k % NR)), SB'(k % NR));
    end
    reset     = 1'b1;
    req_valid = '0;
    #1;
    reset = 1'b0;
    tick();

    // Wrap-around: drive rr_ptr to 3, then requesters 3 and 0 contend.
    req_valid = 4'b0100;
    settle();
    chk("wrap.pre", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b1001;
    settle();
    chk("wrap.ready3", 32'(req_ready), 32'b1000);
    tick();
    chk_out("wrap.w3", 1'b1, 3'd3, 8'h13, 2'd3);
    chk("wrap.ready0", 32'(req_ready), 32'b0001);
    tick();
    chk_out("wrap.w0", 1'b1, 3'd0, 8'h10, 2'd0);
    chk("wrap.ptr1", 32'(req_ready), 32'b1000);
    tick();
    chk("wrap.w3b.src", 32'(wr_src), 32'd3);
    req_valid = 4'b0001;
    settle();
    chk("wrap.ready0b", 32'(req_ready), 32'b0001);
    tick();
    chk("wrap.w0b.src", 32'(wr_src), 32'd0);
    req_valid = '0;
    tick();
    chk("wrap.drain", 32'(wr_en), 32'd0);

    // Stall holds the output stage for three cycles.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    set_req(1, 3'd6, 8'h3C);
    set_req(0, 3'd2, 8'h5A);
    req_valid = 4'b0010;
    settle();
    chk("stall.ready1", 32'(req_ready), 32'b0010);
    tick();
    chk_out("stall.load", 1'b1, 3'd6, 8'h3C, 2'd1);
    wr_stall  = 1'b1;
    req_valid = 4'b0001;
    settle();
    for (int unsigned k = 0; k < 3; k++) begin
      chk($sformatf("stall.ready%0d", k), 32'(req_ready), 32'h0);
      tick();
      chk_out($sformatf("stall.hold%0d", k), 1'b1, 3'd6, 8'h3C, 2'd1);
    end
`ifdef REGFILE_WR_ARB_STATS_EN
    chk("stall.stall_cnt", 32'(stall_cnt), 32'd3);
`endif
    wr_stall = 1'b0;
    settle();
    chk("stall.release_ready", 32'(req_ready), 32'b0001);
    tick();
    chk_out("stall.next", 1'b1, 3'd2, 8'h5A, 2'd0);
    req_valid = '0;
    tick();
    chk("stall.drain", 32'(wr_en), 32'd0);
`ifdef REGFILE_WR_ARB_STATS_EN
    chk("stall.stall_cnt_end", 32'(stall_cnt),    32'd3);
    chk("stall.conflict_cnt",  32'(conflict_cnt), 32'd0);
`endif

    // Same-address hazard: two back-to-back writes to register 4.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    set_req(0, 3'd4, 8'h11);
    set_req(2, 3'd4, 8'h22);
    req_valid = 4'b0101;
    settle();
    chk("haz.ready0", 32'(req_ready), 32'b0001);
    tick();
    chk_out("haz.w0", 1'b1, 3'd4, 8'h11, 2'd0);
    req_valid = 4'b0100;
    settle();
    chk("haz.ready2", 32'(req_ready), 32'b0100);
    tick();
    chk_out("haz.w2", 1'b1, 3'd4, 8'h22, 2'd2);
    req_valid = '0;
    tick();
    chk("haz.drain", 32'(wr_en), 32'd0);
`ifdef REGFILE_WR_ARB_STATS_EN
    chk("haz.conflict_cnt", 32'(conflict_cnt), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
